// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and
// default frame geometry.
package uart_pkg;

   localparam int DEF_DATA_WIDTH   = 8;
   localparam int DEF_CLKS_PER_BIT = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } tx_state_t;

endpackage

// File: rtl/uart_tx_engine_baud.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// final cycle of each serial bit.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = uart_pkg::DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic bit_tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      end
   end

   assign bit_tick = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: pops bytes from a registered-read FIFO and serialises
// start, data (LSB first), optional parity and stop bits onto tx.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tx_en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done,
   output tx_state_t             dbg_state
);

   localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

   tx_state_t             state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [BIT_W-1:0]      bit_cnt;
   logic                  parity_bit;
   logic                  bit_tick;
   logic                  baud_clear;
   logic                  start_ok;
   logic                  last_stop;

   // Handshake: fifo_rd_en is a one-cycle pop request; it is only raised when
   // the FIFO reports data (fifo_empty=0), and fifo_data is sampled in the
   // following cycle (FETCH). It is decoded combinationally so the pop lands
   // on the same edge that leaves IDLE or the final stop cycle.
   assign start_ok   = tx_en && !fifo_empty;
   assign last_stop  = (state == STOP) && bit_tick && (bit_cnt == LAST_STOP);
   assign fifo_rd_en = rst_n && start_ok && ((state == IDLE) || last_stop);
   assign tx_done    = last_stop;
   assign busy       = (state != IDLE);
   assign dbg_state  = state;
   assign baud_clear = (state == IDLE) || (state == FETCH);

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (baud_clear),
      .enable  (!baud_clear),
      .bit_tick(bit_tick)
   );

   // tx is updated on the same edge as the state change, so it always shows
   // the level of the bit the FSM is currently in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tx         <= 1'b1;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         parity_bit <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               tx <= 1'b1;
               if (start_ok) state <= FETCH;
            end
            FETCH: begin
               shift_reg  <= fifo_data;
               parity_bit <= (^fifo_data) ^ (PARITY_ODD != 0);
               bit_cnt    <= '0;
               tx         <= 1'b0;
               state      <= START;
            end
            START: begin
               if (bit_tick) begin
                  tx        <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                  state     <= DATA;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     if (PARITY_EN != 0) begin
                        tx    <= parity_bit;
                        state <= PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     bit_cnt   <= bit_cnt + BIT_W'(1);
                     tx        <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                  end
               end
            end
            PARITY: begin
               if (bit_tick) begin
                  tx    <= 1'b1;
                  state <= STOP;
               end
            end
            STOP: begin
               if (bit_tick) begin
                  if (bit_cnt == LAST_STOP) begin
                     bit_cnt <= '0;
                     tx      <= 1'b1;
                     state   <= start_ok ? FETCH : IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: four parameter variants, per-instance FIFO models
// and a frame-level reference model of the expected serial waveform.
module tb_uart_tx_engine;
   import uart_pkg::*;

   localparam int CLKS = 4;
   localparam int PEN[4]   = '{1, 1, 0, 1};
   localparam int PODD[4]  = '{0, 1, 0, 0};
   localparam int PSTOP[4] = '{1, 1, 1, 2};

   logic       clk;
   logic       rst_n;
   logic [3:0] tx_en_w;
   logic [3:0] empty_w;
   logic [7:0] data_w [4];
   logic [3:0] rd_w, tx_w, busy_w, done_w;
   tx_state_t  st_w [4];

   int checks = 0;
   int failures = 0;

   // FIFO models: bytes loaded by the bench, popped on fifo_rd_en
   logic [7:0] q_data [4][16];
   int q_cnt[4]  = '{default: 0};
   int q_rd[4]   = '{default: 0};
   int pops[4]   = '{default: 0};
   int bad_rd[4] = '{default: 0};

   logic obs_tx [128];
   logic obs_done [128];
   logic obs_busy [128];
   logic obs_rd [128];
   int   last_done_at;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   always_comb begin
      empty_w = '0;
      for (int i = 0; i < 4; i++) empty_w[i] = (q_rd[i] == q_cnt[i]);
   end

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rd_w[i] && empty_w[i]) bad_rd[i] <= bad_rd[i] + 1;
         if (rd_w[i] && !empty_w[i]) begin
            data_w[i] <= q_data[i][q_rd[i] % 16];
            q_rd[i]   <= q_rd[i] + 1;
            pops[i]   <= pops[i] + 1;
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_dut
      uart_tx_engine #(
         .DATA_WIDTH  (8),
         .CLKS_PER_BIT(CLKS),
         .PARITY_EN   (PEN[g]),
         .PARITY_ODD  (PODD[g]),
         .STOP_BITS   (PSTOP[g])
      ) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .tx_en     (tx_en_w[g]),
         .fifo_empty(empty_w[g]),
         .fifo_data (data_w[g]),
         .fifo_rd_en(rd_w[g]),
         .tx        (tx_w[g]),
         .busy      (busy_w[g]),
         .tx_done   (done_w[g]),
         .dbg_state (st_w[g])
      );
   end

   function automatic int flen(input int i);
      return (1 + 8 + PEN[i] + PSTOP[i]) * CLKS;
   endfunction

   // Expected line level c cycles after the first START cycle.
   function automatic logic exp_tx(input int i, input logic [7:0] d, input int c);
      int b;
      b = c / CLKS;
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (PEN[i] != 0 && b == 9) return (^d) ^ (PODD[i] != 0);
      return 1'b1;
   endfunction

   task automatic load(input int i, input logic [7:0] b);
      q_data[i][q_cnt[i] % 16] = b;
      q_cnt[i] = q_cnt[i] + 1;
   endtask

   task automatic wait_pop(input int i, output bit got);
      #1;
      for (int k = 0; k < 20 && !rd_w[i]; k++) @(negedge clk);
      got = rd_w[i];
   endtask

   task automatic capture(input int i, input int n, input int drop_at);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         obs_tx[c]   = tx_w[i];
         obs_done[c] = done_w[i];
         obs_busy[c] = busy_w[i];
         obs_rd[c]   = rd_w[i];
         if (c == drop_at) tx_en_w[i] = 1'b0;
      end
   endtask

   task automatic test_reset();
      int bad;
      rst_n = 1'b0;
      tx_en_w = '0;
      repeat (3) @(negedge clk);
      checks++; if (tx_w !== 4'hF) begin failures++; $display("FAIL reset_tx: got %b want 1111", tx_w); end
      checks++; if (busy_w !== 4'h0) begin failures++; $display("FAIL reset_busy: got %b want 0000", busy_w); end
      checks++; if (done_w !== 4'h0) begin failures++; $display("FAIL reset_done: got %b want 0000", done_w); end
      checks++; if (rd_w !== 4'h0) begin failures++; $display("FAIL reset_rd: got %b want 0000", rd_w); end
      bad = 0;
      for (int i = 0; i < 4; i++) if (st_w[i] !== IDLE) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL reset_state: %0d instances not IDLE, want 0", bad); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy_w !== 4'h0 || tx_w !== 4'hF) begin
         failures++; $display("FAIL post_reset_idle: busy=%b tx=%b want 0000/1111", busy_w, tx_w);
      end
   endtask

   task automatic test_single_frame(input int i, input logic [7:0] b);
      int len, p0, ndone;
      bit got;
      len = flen(i);
      load(i, b);
      p0 = pops[i];
      tx_en_w[i] = 1'b1;
      wait_pop(i, got);
      checks++;
      if (!got) begin
         failures++; $display("FAIL frame_start[%0d]: no fifo_rd_en within 20 cycles", i);
         tx_en_w[i] = 1'b0;
         return;
      end
      @(posedge clk); #1;
      tx_en_w[i] = 1'b0;
      @(negedge clk);
      checks++; if ({tx_w[i], busy_w[i], rd_w[i]} !== 3'b110) begin
         failures++; $display("FAIL fetch[%0d]: tx/busy/rd=%b want 110", i, {tx_w[i], busy_w[i], rd_w[i]});
      end
      capture(i, len + 1, -1);
      ndone = 0;
      last_done_at = -1;
      for (int c = 0; c < len; c++) begin
         checks++; if (obs_tx[c] !== exp_tx(i, b, c)) begin
            failures++; $display("FAIL tx_bit[%0d] data=%h cycle=%0d: got %b want %b", i, b, c, obs_tx[c], exp_tx(i, b, c));
         end
         if (obs_done[c] === 1'b1) begin
            ndone++;
            if (last_done_at < 0) last_done_at = c;
         end
      end
      checks++; if (ndone != 1 || last_done_at != len - 1) begin
         failures++; $display("FAIL tx_done[%0d]: pulses=%0d at=%0d want 1 at %0d", i, ndone, last_done_at, len - 1);
      end
      checks++; if (obs_busy[len] !== 1'b0 || obs_tx[len] !== 1'b1) begin
         failures++; $display("FAIL frame_end[%0d]: busy=%b tx=%b want 0/1", i, obs_busy[len], obs_tx[len]);
      end
      checks++; if (pops[i] - p0 != 1) begin
         failures++; $display("FAIL pop_count[%0d]: got %0d want 1", i, pops[i] - p0);
      end
   endtask

   task automatic test_even_a5();
      int a5_seq[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
      int bad;
      test_single_frame(0, 8'hA5);
      bad = 0;
      for (int k = 0; k < 11; k++) if (obs_tx[k * 4 + 2] !== a5_seq[k][0]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL a5_sequence: %0d bit mismatches, want 0", bad); end
      checks++; if (last_done_at + 1 != 44) begin failures++; $display("FAIL a5_length: done on cycle %0d want 44", last_done_at + 1); end
   endtask

   task automatic test_parity_variants();
      int bad;
      test_single_frame(1, 8'h00);
      checks++; if (obs_tx[37] !== 1'b1) begin failures++; $display("FAIL odd_parity_00: got %b want 1", obs_tx[37]); end
      test_single_frame(2, 8'hFF);
      checks++; if (last_done_at + 1 != 40) begin failures++; $display("FAIL no_parity_len: got %0d want 40", last_done_at + 1); end
      bad = 0;
      for (int c = 36; c < 40; c++) if (obs_tx[c] !== 1'b1) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL no_parity_stop: %0d low cycles want 0", bad); end
      test_single_frame(3, 8'h55);
      checks++; if (last_done_at + 1 != 48) begin failures++; $display("FAIL two_stop_len: got %0d want 48", last_done_at + 1); end
      bad = 0;
      for (int c = 40; c < 48; c++) if (obs_tx[c] !== 1'b1) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL two_stop_level: %0d low cycles want 0", bad); end
   endtask

   task automatic test_random_frames();
      for (int i = 0; i < 4; i++)
         for (int n = 0; n < 3; n++) test_single_frame(i, 8'($urandom_range(0, 255)));
   endtask

   task automatic test_back_to_back();
      int len, p0, bad;
      bit got;
      len = flen(0);
      load(0, 8'h12);
      load(0, 8'h34);
      p0 = pops[0];
      tx_en_w[0] = 1'b1;
      wait_pop(0, got);
      checks++; if (!got) begin failures++; $display("FAIL b2b_start: no fifo_rd_en"); tx_en_w[0] = 1'b0; return; end
      @(posedge clk); #1;
      @(negedge clk);
      capture(0, 2 * len + 2, len);
      bad = 0;
      for (int c = 0; c < len; c++) if (obs_tx[c] !== exp_tx(0, 8'h12, c)) bad++;
      for (int c = 0; c < len; c++) if (obs_tx[len + 1 + c] !== exp_tx(0, 8'h34, c)) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL b2b_bits: %0d mismatching cycles want 0", bad); end
      checks++; if (obs_done[len-1] !== 1'b1 || obs_rd[len-1] !== 1'b1) begin
         failures++; $display("FAIL b2b_handover: done=%b rd=%b want 1/1", obs_done[len-1], obs_rd[len-1]);
      end
      checks++; if (obs_tx[len] !== 1'b1 || obs_tx[len+1] !== 1'b0) begin
         failures++; $display("FAIL b2b_gap: gap tx=%b start tx=%b want 1/0", obs_tx[len], obs_tx[len+1]);
      end
      bad = 0;
      for (int c = 0; c <= 2 * len; c++) if (obs_busy[c] !== 1'b1) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL b2b_busy: %0d idle cycles want 0", bad); end
      checks++; if (obs_busy[2*len+1] !== 1'b0 || obs_rd[2*len] !== 1'b0) begin
         failures++; $display("FAIL b2b_end: busy=%b rd=%b want 0/0", obs_busy[2*len+1], obs_rd[2*len]);
      end
      checks++; if (pops[0] - p0 != 2) begin failures++; $display("FAIL b2b_pops: got %0d want 2", pops[0] - p0); end
   endtask

   task automatic test_idle_hold();
      int bad, p0;
      p0 = pops[0];
      tx_en_w[0] = 1'b1;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (tx_w[0] !== 1'b1 || rd_w[0] !== 1'b0 || busy_w[0] !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL idle_fifo_empty: %0d bad cycles want 0", bad); end
      tx_en_w[0] = 1'b0;
      load(0, 8'h3C);
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (tx_w[0] !== 1'b1 || rd_w[0] !== 1'b0 || busy_w[0] !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL idle_tx_en_low: %0d bad cycles want 0", bad); end
      checks++; if (pops[0] != p0) begin failures++; $display("FAIL idle_pops: got %0d want 0", pops[0] - p0); end
   endtask

   task automatic test_en_drop();
      int len, p0, bad;
      bit got;
      len = flen(0);
      load(0, 8'h81);
      p0 = pops[0];
      tx_en_w[0] = 1'b1;
      wait_pop(0, got);
      checks++; if (!got) begin failures++; $display("FAIL en_drop_start: no fifo_rd_en"); tx_en_w[0] = 1'b0; return; end
      @(posedge clk); #1;
      @(negedge clk);
      capture(0, len + 1, 20);
      bad = 0;
      for (int c = 0; c < len; c++) if (obs_tx[c] !== exp_tx(0, 8'h3C, c)) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL en_drop_bits: %0d mismatching cycles want 0", bad); end
      checks++; if (obs_done[len-1] !== 1'b1 || obs_rd[len-1] !== 1'b0) begin
         failures++; $display("FAIL en_drop_end: done=%b rd=%b want 1/0", obs_done[len-1], obs_rd[len-1]);
      end
      checks++; if (obs_busy[len] !== 1'b0) begin failures++; $display("FAIL en_drop_idle: busy=%b want 0", obs_busy[len]); end
      checks++; if (pops[0] - p0 != 1) begin failures++; $display("FAIL en_drop_pops: got %0d want 1", pops[0] - p0); end
   endtask

   task automatic test_reset_mid_frame();
      int p0, bad;
      bit got;
      tx_en_w[0] = 1'b1;
      wait_pop(0, got);
      checks++; if (!got) begin failures++; $display("FAIL rst_mid_start: no fifo_rd_en"); tx_en_w[0] = 1'b0; return; end
      @(posedge clk); #1;
      tx_en_w[0] = 1'b0;
      @(negedge clk);
      repeat (18) @(negedge clk);
      checks++; if (tx_w[0] !== 1'b0) begin failures++; $display("FAIL rst_mid_bit3: tx=%b want 0", tx_w[0]); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || st_w[0] !== IDLE) begin
         failures++; $display("FAIL rst_mid_async: tx=%b busy=%b state=%0d want 1/0/0", tx_w[0], busy_w[0], st_w[0]);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      load(0, 8'h5A);
      p0 = pops[0];
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (tx_w[0] !== 1'b1 || st_w[0] !== IDLE || rd_w[0] !== 1'b0) bad++;
      end
      checks++; if (bad != 0 || pops[0] != p0) begin
         failures++; $display("FAIL rst_mid_hold: %0d bad cycles, %0d pops want 0/0", bad, pops[0] - p0);
      end
      tx_en_w[0] = 1'b1;
      wait_pop(0, got);
      @(posedge clk); #1;
      tx_en_w[0] = 1'b0;
      checks++; if (!got || pops[0] - p0 != 1) begin
         failures++; $display("FAIL rst_mid_restart: rd=%b pops=%0d want 1/1", got, pops[0] - p0);
      end
      for (int c = 0; c < 100 && busy_w[0] !== 1'b0; c++) @(negedge clk);
      checks++; if (busy_w[0] !== 1'b0) begin failures++; $display("FAIL rst_mid_finish: busy=%b want 0", busy_w[0]); end
   endtask

   initial begin
      rst_n = 1'b0;
      tx_en_w = '0;
      for (int i = 0; i < 4; i++) data_w[i] = 8'h00;
      test_reset();
      test_even_a5();
      test_parity_variants();
      test_random_frames();
      test_back_to_back();
      test_idle_hold();
      test_en_drop();
      test_reset_mid_frame();
      repeat (2) @(negedge clk);
      checks++; if (bad_rd[0] + bad_rd[1] + bad_rd[2] + bad_rd[3] != 0) begin
         failures++; $display("FAIL pop_while_empty: got %0d want 0", bad_rd[0] + bad_rd[1] + bad_rd[2] + bad_rd[3]);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving payload bits per frame.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit (legal range 2..65535).
REQ-003 The block SHALL have parameter PARITY_EN, default 1; 1 inserts a parity bit, 0 omits it.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity.
REQ-005 The block SHALL have parameter STOP_BITS, default 1; legal values are 1 and 2.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port tx_en, input, 1 bit: permits new frames to start.
REQ-009 The block SHALL have port fifo_empty, input, 1 bit: TX FIFO empty flag.
REQ-010 The block SHALL have port fifo_data, input, DATA_WIDTH bits: FIFO read data, registered, valid the cycle after fifo_rd_en.
REQ-011 The block SHALL have port fifo_rd_en, output, 1 bit: one-cycle FIFO pop request.
REQ-012 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse at the end of the final stop bit.

Function
REQ-015 The block SHALL use the states IDLE, FETCH, START, DATA, PARITY and STOP.
REQ-016 IDLE: when tx_en=1 and fifo_empty=0, the block SHALL assert fifo_rd_en for one cycle and go to FETCH; otherwise it SHALL stay in IDLE with tx=1.
REQ-017 FETCH: the block SHALL capture fifo_data into the shift register, compute parity over the captured byte, clear the baud and bit counters, and go to START; FETCH SHALL last exactly 1 cycle.
REQ-018 START SHALL drive tx=0 for CLKS_PER_BIT cycles and then go to DATA.
REQ-019 DATA SHALL drive bits LSB first, each for CLKS_PER_BIT cycles; after bit DATA_WIDTH-1 it SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-020 PARITY SHALL drive XOR(data)^PARITY_ODD for CLKS_PER_BIT cycles and then go to STOP.
REQ-021 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles; on its last cycle tx_done SHALL be 1.
REQ-022 Back-to-back frames: on the last STOP cycle, if tx_en=1 and fifo_empty=0, the block SHALL assert fifo_rd_en in that same cycle and go to FETCH; otherwise it SHALL go to IDLE.
REQ-023 The inter-frame gap under back-to-back frames SHALL be exactly 1 cycle (FETCH), during which tx=1.
REQ-024 tx_en deasserting mid-frame SHALL NOT abort the frame; it SHALL only block the next frame start.
REQ-025 fifo_rd_en SHALL never be asserted while fifo_empty=1 and SHALL never be asserted outside IDLE or the last STOP cycle.
REQ-026 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0; its width SHALL be $clog2(CLKS_PER_BIT).
REQ-027 The bit counter SHALL count 0..DATA_WIDTH-1; its width SHALL be $clog2(DATA_WIDTH)+1.
REQ-028 tx SHALL be driven from a flop, with no combinational glitches.
REQ-029 Frame length SHALL be (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles, measured from the first START cycle.

Reset
REQ-030 While rst_n=0 the block SHALL hold state=IDLE, tx=1, busy=0, tx_done=0, fifo_rd_en=0, and all counters and the shift register at 0.
REQ-031 Reset mid-frame SHALL force tx=1 immediately (asynchronously); the partial frame is discarded and no FIFO pop occurs.
REQ-032 After reset deassertion, the first frame SHALL start no earlier than the first rising edge with tx_en=1 and fifo_empty=0.

Structure
REQ-033 The shared package uart_pkg SHALL hold the state encoding and the default values of CLKS_PER_BIT and DATA_WIDTH.
REQ-034 The baud timing SHALL live in a sub-module uart_baud_gen (inputs clear and enable; output bit_tick on count CLKS_PER_BIT-1).
REQ-035 The state machine, shift register and parity logic SHALL reside in uart_tx_engine.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8)
REQ-036 Single frame, even parity: FIFO holds 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles, 44 cycles total; exactly one fifo_rd_en pulse; tx_done on cycle 44.
REQ-037 Odd parity with 0x00 -> parity bit 1; PARITY_EN=0 with 0xFF -> 40-cycle frame with no parity bit.
REQ-038 Back-to-back: FIFO holds 0x12, 0x34 -> second START begins 1 cycle after the first tx_done; 2 pops total; busy stays high throughout.
REQ-039 fifo_empty=1 or tx_en=0 held for 100 cycles -> tx=1, fifo_rd_en=0, busy=0; tx_en dropped mid-frame -> frame completes, then the block goes to IDLE.
REQ-040 rst_n pulsed low during DATA bit 3 -> tx=1 in the same cycle; state is IDLE after release; no pop until the next start condition.
REQ-041 STOP_BITS=2 with 0x55 -> stop level held for 8 cycles; 48-cycle frame.
